// File: rtl/bcd_display_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_display_scanner : frame-synchronous 4-digit 7-segment scan driver     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module bcd_display_scanner #(
   parameter int PRESCALE = 100000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] h,
   input  logic [3:0] t,
   input  logic [3:0] o,
   input  logic       carry_out,
   input  logic       overflow,
   input  logic       hold,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       frame_tick
);

   localparam int            CW    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST  = CW'(PRESCALE - 1);
   localparam logic [6:0]    BLANK = 7'h7F;

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [3:0]    snap_h;
   logic [3:0]    snap_t;
   logic [3:0]    snap_o;
   logic          snap_c;
   logic          snap_v;
   logic          tick;
   logic [6:0]    seg_next;

   function automatic logic [6:0] dec7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   assign tick = (cnt == LAST);

   // Only a true zero blanks; invalid codes still show the dash.
   always_comb begin
      seg_next = BLANK;
      case (idx)
         2'd0: seg_next = dec7(snap_o);
         2'd1: if (!(BLANK_LZ && snap_h == 4'd0 && snap_t == 4'd0)) seg_next = dec7(snap_t);
         2'd2: if (!(BLANK_LZ && snap_h == 4'd0)) seg_next = dec7(snap_h);
         default: begin
            if (snap_v)      seg_next = 7'h23;
            else if (snap_c) seg_next = 7'h46;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         idx        <= 2'd0;
         snap_h     <= 4'd0;
         snap_t     <= 4'd0;
         snap_o     <= 4'd0;
         snap_c     <= 1'b0;
         snap_v     <= 1'b0;
         seg        <= BLANK;
         an         <= 4'hF;
         frame_tick <= 1'b0;
      end else if (tick) begin
         // Ghost cycle: all anodes off while the digit index advances.
         cnt        <= '0;
         idx        <= idx + 2'd1;
         seg        <= BLANK;
         an         <= 4'hF;
         frame_tick <= (idx == 2'd3);
         if (idx == 2'd3 && !hold) begin
            snap_h <= h;
            snap_t <= t;
            snap_o <= o;
            snap_c <= carry_out;
            snap_v <= overflow;
         end
      end else begin
         cnt        <= cnt + 1'b1;
         seg        <= seg_next;
         an         <= ~(4'b0001 << idx);
         frame_tick <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
// Bench for bcd_display_scanner: table vectors, hand sequences and random
// stimulus against a cycle-position reference model (PRESCALE=4).
module tb_bcd_display_scanner;

   localparam int P     = 4;
   localparam int FRAME = 4 * P;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] h, t, o;
   logic       carry_out, overflow, hold;
   logic [6:0] seg, seg2;
   logic [3:0] an, an2;
   logic       frame_tick, ft2;

   bcd_display_scanner #(.PRESCALE(P), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .h(h), .t(t), .o(o), .carry_out(carry_out),
      .overflow(overflow), .hold(hold), .seg(seg), .an(an), .frame_tick(frame_tick)
   );

   bcd_display_scanner #(.PRESCALE(P), .BLANK_LZ(1'b0)) dut_nolz (
      .clk(clk), .rst_n(rst_n), .h(h), .t(t), .o(o), .carry_out(carry_out),
      .overflow(overflow), .hold(hold), .seg(seg2), .an(an2), .frame_tick(ft2)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // reference model state
   int         k;
   logic [3:0] m_h, m_t, m_o;
   logic       m_c, m_v;
   logic [3:0] exp_an;
   logic [6:0] exp_seg, exp_seg2;
   logic       exp_ft;
   logic [6:0] lut [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   typedef struct {
      logic [3:0] vh, vt, vo;
      logic       vc, vv;
      logic [6:0] e_o, e_t, e_h, e_s, e_h0;
   } vec_t;
   vec_t tbl [7];

   function automatic logic [6:0] glyph(input logic [3:0] d);
      if (d > 4'd9) return 7'h3F;
      return lut[int'(d)];
   endfunction

   function automatic logic [6:0] slot_seg(input int slot, input bit blz);
      case (slot)
         0: return glyph(m_o);
         1: return (blz && m_h == 0 && m_t == 0) ? 7'h7F : glyph(m_t);
         2: return (blz && m_h == 0) ? 7'h7F : glyph(m_h);
         default: return m_v ? 7'h23 : (m_c ? 7'h46 : 7'h7F);
      endcase
   endfunction

   // Expected outputs are a function of the edge count since reset release.
   task automatic model_edge();
      int p, slot;
      if (!rst_n) begin
         k = 0; m_h = 0; m_t = 0; m_o = 0; m_c = 0; m_v = 0;
         exp_an = 4'hF; exp_seg = 7'h7F; exp_seg2 = 7'h7F; exp_ft = 1'b0;
      end else begin
         p    = k % FRAME;
         slot = p / P;
         if (p % P == P - 1) begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_seg2 = 7'h7F;
            exp_ft = (slot == 3);
            if (slot == 3 && !hold) begin
               m_h = h; m_t = t; m_o = o; m_c = carry_out; m_v = overflow;
            end
         end else begin
            exp_an   = 4'hF ^ (4'b0001 << slot);
            exp_seg  = slot_seg(slot, 1'b1);
            exp_seg2 = slot_seg(slot, 1'b0);
            exp_ft   = 1'b0;
         end
         k++;
      end
   endtask

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("an",        {3'b0, an},         {3'b0, exp_an});
      chk("seg",       seg,                exp_seg);
      chk("frame_tick",{6'b0, frame_tick}, {6'b0, exp_ft});
      chk("an_nolz",   {3'b0, an2},        {3'b0, exp_an});
      chk("seg_nolz",  seg2,               exp_seg2);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_frame();
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (frame_tick !== 1'b1 && n < 3 * FRAME);
      if (frame_tick !== 1'b1) begin
         total++;
         $display("FAIL frame_timeout: frame_tick got %b required 1", frame_tick);
      end
   endtask

   task automatic set_in(input logic [3:0] a, b, c, input logic cy, ov);
      h = a; t = b; o = c; carry_out = cy; overflow = ov;
   endtask

   initial begin
      tbl[0] = '{4'd2, 4'd5, 4'd5, 1'b0, 1'b0, 7'h12, 7'h12, 7'h24, 7'h7F, 7'h24};
      tbl[1] = '{4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 7'h78, 7'h7F, 7'h7F, 7'h7F, 7'h40};
      tbl[2] = '{4'd0, 4'd3, 4'd1, 1'b0, 1'b0, 7'h79, 7'h30, 7'h7F, 7'h7F, 7'h40};
      tbl[3] = '{4'd9, 4'd0, 4'd8, 1'b1, 1'b0, 7'h00, 7'h40, 7'h10, 7'h46, 7'h10};
      tbl[4] = '{4'd1, 4'd0, 4'hC, 1'b1, 1'b1, 7'h3F, 7'h40, 7'h79, 7'h23, 7'h79};
      tbl[5] = '{4'd0, 4'hA, 4'd6, 1'b0, 1'b1, 7'h02, 7'h3F, 7'h7F, 7'h23, 7'h40};
      tbl[6] = '{4'hF, 4'd0, 4'd0, 1'b0, 1'b0, 7'h40, 7'h40, 7'h3F, 7'h7F, 7'h3F};

      rst_n = 1'b0; hold = 1'b0;
      set_in(4'd2, 4'd5, 4'd5, 1'b0, 1'b0);
      k = 0; m_h = 0; m_t = 0; m_o = 0; m_c = 0; m_v = 0;

      // reset and first scan
      steps(3);
      chk("reset_an",  {3'b0, an}, 7'h0F);
      chk("reset_seg", seg,        7'h7F);
      rst_n = 1'b1;
      step();
      chk("first_an",  {3'b0, an}, 7'h0E);
      chk("first_seg", seg,        7'h40);
      steps(3);
      chk("first_ghost_an", {3'b0, an}, 7'h0F);

      // table-driven frames
      foreach (tbl[i]) begin
         set_in(tbl[i].vh, tbl[i].vt, tbl[i].vo, tbl[i].vc, tbl[i].vv);
         wait_frame();
         step();
         chk($sformatf("v%0d_ones", i), seg, tbl[i].e_o);
         steps(P);
         chk($sformatf("v%0d_tens", i), seg, tbl[i].e_t);
         steps(P);
         chk($sformatf("v%0d_hund", i), seg, tbl[i].e_h);
         chk($sformatf("v%0d_hund_nolz", i), seg2, tbl[i].e_h0);
         steps(P);
         chk($sformatf("v%0d_stat", i), seg, tbl[i].e_s);
      end

      // mid-frame change, hold across a boundary, then release
      set_in(4'd0, 4'd0, 4'd3, 1'b0, 1'b0);
      wait_frame();
      step();
      chk("snap_ones", seg, 7'h30);
      steps(5);
      o = 4'd8;
      steps(6);
      hold = 1'b1;
      wait_frame();
      step();
      chk("hold_retain", seg, 7'h30);
      hold = 1'b0;
      wait_frame();
      step();
      chk("hold_release", seg, 7'h00);

      // reset asserted during the status slot
      begin
         int n;
         n = 0;
         while (an !== 4'h7 && n < 2 * FRAME) begin
            step();
            n++;
         end
         chk("reach_status_an", {3'b0, an}, 7'h07);
      end
      rst_n = 1'b0;
      step();
      chk("midrst_an",  {3'b0, an}, 7'h0F);
      chk("midrst_seg", seg,        7'h7F);
      chk("midrst_ft",  {6'b0, frame_tick}, 7'h00);
      rst_n = 1'b1;
      step();
      chk("postrst_an",  {3'b0, an}, 7'h0E);
      chk("postrst_seg", seg,        7'h40);

      // randomized stimulus against the model
      for (int i = 0; i < 400; i++) begin
         h = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         t = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         o = 4'($urandom_range(0, 15));
         carry_out = 1'($urandom_range(0, 1));
         overflow  = ($urandom_range(0, 3) == 0);
         hold      = ($urandom_range(0, 3) == 0);
         step();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
